reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 72 +++++++
 tb/tb_reg_file_mp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with PC/CPSR, write bypass and per-register busy scoreboard.
module reg_file_mp #(
    parameter int N    = 32,
    parameter int NREG = 16,
    parameter int NRD  = 4,
    parameter int NWR  = 4,
    parameter int AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*N-1:0]  rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*N-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              pc_write,
    input  logic [N-1:0]      pc_update,
    output logic [N-1:0]      pc,
    input  logic              cpsr_write,
    input  logic [N-1:0]      cpsr_update,
    output logic [N-1:0]      cpsr
);
    logic [N-1:0]    regs     [NREG];
    logic [N-1:0]    nxt_regs [NREG];
    logic [NREG-1:0] busy, nxt_busy;

    function automatic logic ok(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREG);
    endfunction

    always_comb begin
        nxt_regs = regs;
        nxt_busy = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && ok(wr_addr[j*AW +: AW])) begin
                nxt_regs[wr_addr[j*AW +: AW]] = wr_data[j*N +: N];
                nxt_busy[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (pc_write) begin
            nxt_regs[NREG-1] = pc_update;
            nxt_busy[NREG-1] = 1'b0;
        end
        if (rsv_en && ok(rsv_addr))
            nxt_busy[rsv_addr] = 1'b1;
    end

    // reads sample the post-commit state, which gives the same-cycle bypass for free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs    <= '{default: '0};
            busy    <= '0;
            cpsr    <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            regs <= nxt_regs;
            busy <= nxt_busy;
            if (cpsr_write)
                cpsr <= cpsr_update;
            for (int i = 0; i < NRD; i++) begin
                rd_data[i*N +: N] <= ok(rd_addr[i*AW +: AW]) ? nxt_regs[rd_addr[i*AW +: AW]] : '0;
                rd_busy[i]        <= ok(rd_addr[i*AW +: AW]) && nxt_busy[rd_addr[i*AW +: AW]];
            end
        end
    end

    assign pc = regs[NREG-1];
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized model-checked bench for reg_file_mp plus directed and parameter-sweep cases.
module tb_reg_file_mp;
    localparam int N = 32, NREG = 16, NRD = 4, NWR = 4, AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*N-1:0]  rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*N-1:0]  wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              pc_write;
    logic [N-1:0]      pc_update, pc;
    logic              cpsr_write;
    logic [N-1:0]      cpsr_update, cpsr;

    reg_file_mp #(.N(N), .NREG(NREG), .NRD(NRD), .NWR(NWR), .AW(AW)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pc_write(pc_write), .pc_update(pc_update), .pc(pc),
        .cpsr_write(cpsr_write), .cpsr_update(cpsr_update), .cpsr(cpsr)
    );

    logic [5:0]  s1_rd_addr;
    logic [31:0] s1_rd_data;
    logic [1:0]  s1_rd_busy;
    logic [0:0]  s1_wr_en = '0;
    logic [2:0]  s1_wr_addr = '0;
    logic [15:0] s1_wr_data = '0;
    logic [15:0] s1_pc, s1_cpsr;

    reg_file_mp #(.N(16), .NREG(8), .NRD(2), .NWR(1), .AW(3)) s1 (
        .clk(clk), .rst(rst), .rd_addr(s1_rd_addr), .rd_data(s1_rd_data), .rd_busy(s1_rd_busy),
        .wr_en(s1_wr_en), .wr_addr(s1_wr_addr), .wr_data(s1_wr_data), .rsv_en(1'b0), .rsv_addr(3'd0),
        .pc_write(1'b0), .pc_update(16'd0), .pc(s1_pc),
        .cpsr_write(1'b0), .cpsr_update(16'd0), .cpsr(s1_cpsr)
    );

    logic [29:0]  s2_rd_addr;
    logic [383:0] s2_rd_data;
    logic [5:0]   s2_rd_busy;
    logic [2:0]   s2_wr_en = '0;
    logic [14:0]  s2_wr_addr = '0;
    logic [191:0] s2_wr_data = '0;
    logic [63:0]  s2_pc, s2_cpsr;

    reg_file_mp #(.N(64), .NREG(32), .NRD(6), .NWR(3), .AW(5)) s2 (
        .clk(clk), .rst(rst), .rd_addr(s2_rd_addr), .rd_data(s2_rd_data), .rd_busy(s2_rd_busy),
        .wr_en(s2_wr_en), .wr_addr(s2_wr_addr), .wr_data(s2_wr_data), .rsv_en(1'b0), .rsv_addr(5'd0),
        .pc_write(1'b0), .pc_update(64'd0), .pc(s2_pc),
        .cpsr_write(1'b0), .cpsr_update(64'd0), .cpsr(s2_cpsr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // reference state: architectural registers, scoreboard, cpsr
    logic [N-1:0] m_regs [NREG];
    logic         m_busy [NREG];
    logic [N-1:0] m_cpsr;

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_cpsr = '0;
    endtask

    task automatic model_step();
        int w;
        logic pcw, wrote;
        if (rst) begin
            model_clear();
            return;
        end
        for (int r = 0; r < NREG; r++) begin
            w = -1;
            for (int j = NWR - 1; j >= 0; j--)
                if (w < 0 && wr_en[j] && int'(wr_addr[j*AW +: AW]) == r) w = j;
            pcw   = pc_write && r == NREG - 1;
            wrote = pcw || w >= 0;
            if (pcw) m_regs[r] = pc_update;
            else if (w >= 0) m_regs[r] = wr_data[w*N +: N];
            if (rsv_en && int'(rsv_addr) == r) m_busy[r] = 1'b1;
            else if (wrote) m_busy[r] = 1'b0;
        end
        if (cpsr_write) m_cpsr = cpsr_update;
    endtask

    task automatic check_all();
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rd_data%0d", i), 64'(rd_data[i*N +: N]), 64'(m_regs[rd_addr[i*AW +: AW]]));
            chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(m_busy[rd_addr[i*AW +: AW]]));
        end
        chk("pc", 64'(pc), 64'(m_regs[NREG-1]));
        chk("cpsr", 64'(cpsr), 64'(m_cpsr));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; pc_write = 1'b0; pc_update = '0;
        cpsr_write = 1'b0; cpsr_update = '0;
    endtask

    task automatic randomize_inputs();
        for (int j = 0; j < NWR; j++) begin
            wr_addr[j*AW +: AW] = AW'($urandom_range(1) ? $urandom_range(NREG-1) : $urandom_range(NREG-1, NREG-3));
            wr_data[j*N +: N]   = N'($urandom);
        end
        for (int i = 0; i < NRD; i++)
            rd_addr[i*AW +: AW] = AW'($urandom_range(1) ? $urandom_range(NREG-1) : $urandom_range(NREG-1, NREG-3));
        wr_en       = NWR'($urandom);
        rsv_en      = $urandom_range(3) == 0;
        rsv_addr    = AW'($urandom_range(NREG-1));
        pc_write    = $urandom_range(4) == 0;
        pc_update   = N'($urandom);
        cpsr_write  = $urandom_range(3) == 0;
        cpsr_update = N'($urandom);
    endtask

    function automatic logic [15:0] s1_val(input int r);
        return 16'hA000 + 16'(r * 273);
    endfunction

    function automatic logic [63:0] s2_val(input int r);
        return 64'hC0DE_0000_0000_0000 + 64'(r) * 64'h1_0000_0101;
    endfunction

    initial begin
        idle();
        model_clear();
        s1_rd_addr = '0;
        s2_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        for (int c = 0; c < 200; c++) begin
            randomize_inputs();
            tick();
        end

        // asynchronous reset between edges, with writes pending
        randomize_inputs();
        wr_en = '1;
        #3 rst = 1'b1;
        #1;
        model_clear();
        check_all();
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        tick();
        chk("rst_hold_pc", 64'(pc), 64'd0);
        rst = 1'b0;

        idle();
        wr_en = 4'b1111;
        wr_addr = {4'd3, 4'd3, 4'd3, 4'd3};
        wr_data = {32'd44, 32'd33, 32'd22, 32'd11};
        rd_addr[0 +: AW] = 4'd3;
        tick();
        chk("prio_bypass", 64'(rd_data[0 +: N]), 64'd44);
        idle();
        rd_addr[0 +: AW] = 4'd3;
        tick();
        chk("prio_hold", 64'(rd_data[0 +: N]), 64'd44);

        idle();
        pc_write = 1'b1;
        pc_update = 32'h100;
        wr_en = 4'b0010;
        wr_addr[AW +: AW] = 4'd15;
        wr_data[N +: N] = 32'h200;
        rd_addr[2*AW +: AW] = 4'd15;
        tick();
        chk("pc_over", 64'(pc), 64'h100);
        chk("pc_read", 64'(rd_data[2*N +: N]), 64'h100);

        idle();
        rsv_en = 1'b1;
        rsv_addr = 4'd5;
        tick();
        idle();
        rd_addr[0 +: AW] = 4'd5;
        tick();
        chk("rsv_busy", 64'(rd_busy[0]), 64'd1);
        idle();
        wr_en = 4'b0001;
        wr_addr[0 +: AW] = 4'd5;
        wr_data[0 +: N] = 32'd7;
        rd_addr[0 +: AW] = 4'd5;
        tick();
        chk("wr_clr_data", 64'(rd_data[0 +: N]), 64'd7);
        chk("wr_clr_busy", 64'(rd_busy[0]), 64'd0);
        idle();
        rsv_en = 1'b1;
        rsv_addr = 4'd5;
        wr_en = 4'b1000;
        wr_addr[3*AW +: AW] = 4'd5;
        wr_data[3*N +: N] = 32'd9;
        rd_addr[AW +: AW] = 4'd5;
        tick();
        chk("rsv_wins_data", 64'(rd_data[N +: N]), 64'd9);
        chk("rsv_wins_busy", 64'(rd_busy[1]), 64'd1);

        for (int c = 0; c < 200; c++) begin
            randomize_inputs();
            tick();
        end
        idle();

        for (int r = 0; r < 8; r++) begin
            s1_wr_en = 1'b1;
            s1_wr_addr = 3'(r);
            s1_wr_data = s1_val(r);
            s1_rd_addr = {3'(r), 3'(r)};
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                chk($sformatf("s1_byp%0d_r%0d", i, r), 64'(s1_rd_data[i*16 +: 16]), 64'(s1_val(r)));
        end
        s1_wr_en = 1'b0;
        for (int r = 0; r < 8; r++) begin
            s1_rd_addr = {3'(7 - r), 3'(r)};
            @(posedge clk);
            #1;
            chk($sformatf("s1_rd0_r%0d", r), 64'(s1_rd_data[15:0]), 64'(s1_val(r)));
            chk($sformatf("s1_rd1_r%0d", r), 64'(s1_rd_data[31:16]), 64'(s1_val(7 - r)));
        end
        chk("s1_pc", 64'(s1_pc), 64'(s1_val(7)));
        chk("s1_cpsr", 64'(s1_cpsr), 64'd0);

        for (int r = 0; r < 32; r++) begin
            s2_wr_en = 3'(1 << (r % 3));
            for (int j = 0; j < 3; j++) begin
                s2_wr_addr[j*5 +: 5] = 5'(r);
                s2_wr_data[j*64 +: 64] = {$urandom, $urandom};
            end
            s2_wr_data[(r % 3)*64 +: 64] = s2_val(r);
            for (int i = 0; i < 6; i++) s2_rd_addr[i*5 +: 5] = 5'(r);
            @(posedge clk);
            #1;
            for (int i = 0; i < 6; i++)
                chk($sformatf("s2_byp%0d_r%0d", i, r), s2_rd_data[i*64 +: 64], s2_val(r));
        end
        s2_wr_en = '0;
        for (int r = 0; r < 32; r++) begin
            for (int i = 0; i < 6; i++) s2_rd_addr[i*5 +: 5] = 5'((r + i) % 32);
            @(posedge clk);
            #1;
            for (int i = 0; i < 6; i++)
                chk($sformatf("s2_rd%0d_r%0d", i, r), s2_rd_data[i*64 +: 64], s2_val((r + i) % 32));
        end
        chk("s2_pc", s2_pc, s2_val(31));
        chk("s2_cpsr", s2_cpsr, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
